// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache block fill controller: block geometry,
// FSM state encoding and address helpers.
package cache_fill_fsm_pkg;

    localparam int unsigned ADDR_WIDTH        = 16;
    localparam int unsigned BLOCK_WORDS       = 8;
    localparam int unsigned OFFSET_WIDTH      = $clog2(BLOCK_WORDS);
    localparam int unsigned WORD_BYTES        = 2;
    localparam int unsigned BLOCK_BYTES       = BLOCK_WORDS * WORD_BYTES;
    localparam int unsigned BYTE_OFFSET_WIDTH = $clog2(BLOCK_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

    // Align a byte address down to the start of its cache block.
    function automatic logic [ADDR_WIDTH-1:0] block_base(input logic [ADDR_WIDTH-1:0] addr);
        block_base = {addr[ADDR_WIDTH-1:BYTE_OFFSET_WIDTH], {BYTE_OFFSET_WIDTH{1'b0}}};
    endfunction

    // Byte address of word 'idx' inside the block starting at 'base'.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0]   base,
                                                        input logic [OFFSET_WIDTH-1:0] idx);
        word_addr = base + {{(ADDR_WIDTH-OFFSET_WIDTH-1){1'b0}}, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter used by the fill controller for both issued reads and
// returned words. Sync clear has priority over enable; terminal marks the
// last word of a block.
module fill_counter
    import cache_fill_fsm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    enable,
    output logic [OFFSET_WIDTH-1:0] count,
    output logic                    terminal
);

    // Count words; clear restarts the block, async reset forces zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + OFFSET_WIDTH'(1);
        end
    end

    // Flag the final word index of the block.
    always_comb begin
        terminal = (count == OFFSET_WIDTH'(BLOCK_WORDS - 1));
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss block-fill controller. On a miss it stalls the pipeline, issues
// one read per cycle for each word of the block, writes each returned word
// into the data array and writes the tag when the last word arrives.
// Completion is counted by returned words, so memory latency is not assumed.
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        memory_read,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  word_offset,
    output logic        write_tag_array
);

    fill_state_t                 state;
    logic [ADDR_WIDTH-1:0]       base;
    logic                        issue_done;

    logic [OFFSET_WIDTH-1:0]     issue_cnt;
    logic [OFFSET_WIDTH-1:0]     recv_cnt;
    logic                        issue_term;
    logic                        recv_term;
    logic                        start_fill;
    logic                        recv_en;

    // A new fill starts only from IDLE; misses during FILL are ignored.
    always_comb begin
        start_fill = (state == IDLE) && miss_detected;
        recv_en    = (state == FILL) && memory_data_valid;
    end

    fill_counter u_issue_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_fill),
        .enable   (memory_read),
        .count    (issue_cnt),
        .terminal (issue_term)
    );

    fill_counter u_recv_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_fill),
        .enable   (recv_en),
        .count    (recv_cnt),
        .terminal (recv_term)
    );

    // Fill sequencing: latch the block base on a miss, stop issuing after the
    // last word, and return to IDLE when the last word has been received.
    // issue_done extends the 3-bit issue counter to represent "all 8 issued".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            issue_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        state      <= FILL;
                        base       <= block_base(miss_address);
                        issue_done <= 1'b0;
                    end
                end
                FILL: begin
                    if (memory_read && issue_term) begin
                        issue_done <= 1'b1;
                    end
                    if (recv_en && recv_term) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs react within the cycle: the stall asserts in the miss cycle and
    // array writes coincide with the returned word.
    always_comb begin
        fsm_busy         = (state == FILL) || start_fill;
        memory_read      = (state == FILL) && !issue_done;
        memory_address   = memory_read ? word_addr(base, issue_cnt) : base;
        write_data_array = recv_en;
        word_offset      = recv_en ? recv_cnt : '0;
        write_tag_array  = recv_en && recv_term;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a fixed vector table for the
// nominal fill, directed corner sequences and randomized fills, all checked
// against a word-counting reference model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic        write_tag_array;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_offset       (word_offset),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: is a fill in progress, its block base, and how many
    // words have been requested and received so far.
    bit          m_fill;
    logic [15:0] m_base;
    int          m_issued;
    int          m_recv;
    logic [15:0] rd_hist;

    // Observed-behaviour statistics per fill.
    int          tag_cnt, wda_cnt, tag_at_pulse, rd_cnt;
    logic [15:0] first_rd, last_rd;

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        wda;
        logic [2:0]  off;
        logic        tag;
    } vec_t;

    vec_t tab[14];
    vec_t nov;

    function automatic vec_t mkv(logic mi, logic [15:0] a, logic v, logic b, logic r,
                                 logic [15:0] ma, logic w, logic [2:0] o, logic t);
        vec_t x;
        x.miss = mi; x.addr = a; x.valid = v; x.busy = b; x.rd = r;
        x.maddr = ma; x.wda = w; x.off = o; x.tag = t;
        return x;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill = 1'b0; m_base = '0; m_issued = 0; m_recv = 0; rd_hist = '0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the
    // model (and optionally a table row), then advance the model at the edge.
    task automatic step(input logic miss, input logic [15:0] addr, input logic valid,
                        input bit use_tab, input vec_t v);
        logic        e_busy, e_read, e_wda, e_tag;
        logic [15:0] e_addr;
        logic [2:0]  e_off;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = valid;
        e_busy = m_fill || miss;
        e_read = m_fill && (m_issued < 8);
        e_addr = e_read ? 16'(m_base + 16'(2 * m_issued)) : m_base;
        e_wda  = m_fill && valid;
        e_off  = e_wda ? 3'(m_recv) : 3'd0;
        e_tag  = e_wda && (m_recv == 7);
        @(negedge clk);
        chk("busy",  16'(fsm_busy),         16'(e_busy));
        chk("read",  16'(memory_read),      16'(e_read));
        chk("addr",  memory_address,        e_addr);
        chk("wda",   16'(write_data_array), 16'(e_wda));
        chk("off",   16'(word_offset),      16'(e_off));
        chk("tag",   16'(write_tag_array),  16'(e_tag));
        if (use_tab) begin
            chk("tab_busy", 16'(fsm_busy),         16'(v.busy));
            chk("tab_read", 16'(memory_read),      16'(v.rd));
            chk("tab_addr", memory_address,        v.maddr);
            chk("tab_wda",  16'(write_data_array), 16'(v.wda));
            chk("tab_off",  16'(word_offset),      16'(v.off));
            chk("tab_tag",  16'(write_tag_array),  16'(v.tag));
        end
        if (write_data_array === 1'b1) wda_cnt++;
        if (write_tag_array === 1'b1) begin
            tag_cnt++;
            tag_at_pulse = wda_cnt;
        end
        if (memory_read === 1'b1) begin
            if (rd_cnt == 0) first_rd = memory_address;
            last_rd = memory_address;
            rd_cnt++;
        end
        @(posedge clk);
        rd_hist = {rd_hist[14:0], e_read};
        if (!m_fill) begin
            if (miss) begin
                m_fill = 1'b1; m_base = addr & 16'hFFF0; m_issued = 0; m_recv = 0;
            end
        end else begin
            if (e_read) m_issued++;
            if (e_wda) begin
                m_recv++;
                if (m_recv == 8) m_fill = 1'b0;
            end
        end
        #1;
    endtask

    task automatic clear_stats();
        tag_cnt = 0; wda_cnt = 0; tag_at_pulse = 0; rd_cnt = 0;
        first_rd = '0; last_rd = '0;
    endtask

    // One complete fill. gap==0: memory answers each read 'lat' cycles later.
    // gap>0: one word returns every gap+1 cycles while reads are outstanding.
    task automatic run_fill(input logic [15:0] addr, input int lat, input int gap,
                            input bit noise);
        logic        v, mn;
        logic [15:0] ma;
        logic [15:0] b;
        b = addr & 16'hFFF0;
        clear_stats();
        rd_hist = '0;
        step(1'b1, addr, 1'b0, 1'b0, nov);
        for (int c = 1; c < 80 && m_fill; c++) begin
            if (gap == 0) v = rd_hist[lat-1];
            else          v = ((c % (gap + 1)) == 0) && (m_issued > m_recv);
            mn = noise ? 1'($urandom % 2) : 1'b0;
            ma = 16'($urandom);
            step(mn, ma, v, 1'b0, nov);
        end
        chk("fill_tag_count",  16'(tag_cnt),      16'd1);
        chk("fill_tag_on_8th", 16'(tag_at_pulse), 16'd8);
        chk("fill_read_count", 16'(rd_cnt),       16'd8);
        chk("fill_first_read", first_rd,          b);
        chk("fill_last_read",  last_rd,           16'(b + 16'd14));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nov = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Miss at 0x1236 with 4-cycle memory: reads cycles 1-8, words 5-12.
        tab[0]  = mkv(1, 16'h1236, 0, 1, 0, 16'h0000, 0, 0, 0);
        tab[1]  = mkv(0, 16'h0000, 0, 1, 1, 16'h1230, 0, 0, 0);
        tab[2]  = mkv(0, 16'h0000, 0, 1, 1, 16'h1232, 0, 0, 0);
        tab[3]  = mkv(0, 16'h0000, 0, 1, 1, 16'h1234, 0, 0, 0);
        tab[4]  = mkv(0, 16'h0000, 0, 1, 1, 16'h1236, 0, 0, 0);
        tab[5]  = mkv(0, 16'h0000, 1, 1, 1, 16'h1238, 1, 0, 0);
        tab[6]  = mkv(0, 16'h0000, 1, 1, 1, 16'h123A, 1, 1, 0);
        tab[7]  = mkv(0, 16'h0000, 1, 1, 1, 16'h123C, 1, 2, 0);
        tab[8]  = mkv(0, 16'h0000, 1, 1, 1, 16'h123E, 1, 3, 0);
        tab[9]  = mkv(0, 16'h0000, 1, 1, 0, 16'h1230, 1, 4, 0);
        tab[10] = mkv(0, 16'h0000, 1, 1, 0, 16'h1230, 1, 5, 0);
        tab[11] = mkv(0, 16'h0000, 1, 1, 0, 16'h1230, 1, 6, 0);
        tab[12] = mkv(0, 16'h0000, 1, 1, 0, 16'h1230, 1, 7, 1);
        tab[13] = mkv(0, 16'h0000, 0, 0, 0, 16'h1230, 0, 0, 0);

        // Reset values.
        rst = 1'b1; miss_detected = 1'b0; miss_address = '0; memory_data_valid = 1'b0;
        model_reset();
        clear_stats();
        #2;
        chk("reset_busy", 16'(fsm_busy),         16'd0);
        chk("reset_read", 16'(memory_read),      16'd0);
        chk("reset_addr", memory_address,        16'h0000);
        chk("reset_wda",  16'(write_data_array), 16'd0);
        chk("reset_off",  16'(word_offset),      16'd0);
        chk("reset_tag",  16'(write_tag_array),  16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal fill from the table.
        for (int i = 0; i < 14; i++) begin
            step(tab[i].miss, tab[i].addr, tab[i].valid, 1'b1, tab[i]);
        end

        // Returned-word strobes while idle must be ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 16'h5555, 1'b1, 1'b0, nov);

        // Spurious miss to 0xFFFE throughout the fill of 0x1230.
        clear_stats();
        rd_hist = '0;
        step(1'b1, 16'h1230, 1'b0, 1'b0, nov);
        for (int c = 1; c < 40 && m_fill; c++) step(1'b1, 16'hFFFE, rd_hist[3], 1'b0, nov);
        chk("noise_tag_count", 16'(tag_cnt), 16'd1);
        chk("noise_last_read", last_rd, 16'h123E);
        step(1'b0, 16'h0000, 1'b0, 1'b0, nov);
        chk("noise_base_kept", memory_address, 16'h1230);
        chk("noise_not_busy",  16'(fsm_busy),  16'd0);

        // Gapped returns: completion follows the 8th word, not elapsed time.
        run_fill(16'h4444, 0, 2, 1'b0);

        // Reset after the third returned word abandons the fill.
        clear_stats();
        rd_hist = '0;
        step(1'b1, 16'h2000, 1'b0, 1'b0, nov);
        for (int c = 0; c < 20 && m_recv < 3; c++) step(1'b0, 16'h0000, rd_hist[3], 1'b0, nov);
        chk("midrst_words_before", 16'(wda_cnt), 16'd3);
        miss_detected = 1'b0; memory_data_valid = 1'b1; rst = 1'b1;
        #1;
        chk("midrst_busy", 16'(fsm_busy),         16'd0);
        chk("midrst_read", 16'(memory_read),      16'd0);
        chk("midrst_addr", memory_address,        16'h0000);
        chk("midrst_wda",  16'(write_data_array), 16'd0);
        chk("midrst_off",  16'(word_offset),      16'd0);
        chk("midrst_tag",  16'(write_tag_array),  16'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, nov);
        chk("midrst_no_tag", 16'(tag_cnt), 16'd0);

        // Back-to-back misses; the second starts the cycle after returning idle.
        run_fill(16'h0010, 4, 0, 1'b0);
        run_fill(16'hFFF0, 4, 0, 1'b0);

        // Randomized fills with varied latency, gaps, idle strobes and noise.
        for (int n = 0; n < 25; n++) begin
            int k;
            k = int'($urandom_range(0, 2));
            for (int i = 0; i < k; i++) step(1'b0, 16'($urandom), 1'($urandom % 2), 1'b0, nov);
            run_fill(16'($urandom), int'($urandom_range(1, 8)),
                     ($urandom % 2) ? int'($urandom_range(1, 3)) : 0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
